digit_serial_multiplier: RTL and testbench
==========================================

DIGIT_SERIAL_MULTIPLIER -- requirements
Module: digit_serial_multiplier

Interface
REQ-001 SHALL provide parameter WA, default 6: width of multiplicand number1.
REQ-002 SHALL provide parameter WB, default 9: width of multiplier number2; WB SHALL be a positive multiple of DIGIT.
REQ-003 SHALL provide parameter DIGIT, default 3: multiplier bits consumed per cycle.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 in_valid  input  1  operands on number1/number2 are valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 number1  input  WA  unsigned multiplicand.
REQ-009 number2  input  WB  unsigned multiplier.
REQ-010 out_valid  output  1  result is valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WA+WB  unsigned product number1*number2.

Function
REQ-013 SHALL define ND = WB/DIGIT digit steps per operation.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE: on an edge with in_valid=1, SHALL register number1, number2, clear accumulator and digit counter, and go to RUN; otherwise stay in IDLE.
REQ-016 RUN: each cycle SHALL add number1 * digit[k] << (DIGIT*k) to the accumulator, where digit[k] = number2 bits [DIGIT*k+DIGIT-1 : DIGIT*k], k = 0..ND-1, LSB digit first, and increment k.
REQ-017 RUN: after the step with k = ND-1, SHALL go to DONE with the complete product in result.
REQ-018 Latency: out_valid SHALL rise exactly ND cycles after the accepting edge (3 cycles for default parameters, 1 cycle for WB=DIGIT).
REQ-019 DONE: result and out_valid SHALL be held stable until an edge with out_ready=1, then go to IDLE.
REQ-020 DONE with in_valid=1 and out_ready=1 together: SHALL return to IDLE without accepting the new operands (in_ready=0 that cycle); they are accepted no earlier than the next edge.
REQ-021 Operand changes on number1/number2 after acceptance SHALL NOT affect the result in progress.
REQ-022 Accumulator SHALL be WA+WB bits; no overflow is possible (max (2^WA-1)*(2^WB-1) fits); no truncation permitted.
REQ-023 result SHALL retain its last value in IDLE and RUN; consumers qualify it with out_valid only.
REQ-024 Zero operands SHALL take the full ND cycles (no early termination).
REQ-025 Back-to-back throughput SHALL be one operation per ND+2 cycles when out_ready is held high.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, in_ready=1, out_valid=0, result=0, accumulator=0, digit counter=0.
REQ-027 rst asserted in RUN or DONE SHALL abort the operation; no result of the aborted operation SHALL ever appear.
REQ-028 First acceptance after rst deassertion SHALL occur on the first edge with rst=0 and in_valid=1.

Verification
REQ-029 Defaults: number1=45, number2=300, in_valid one cycle, out_ready=1 -> out_valid 3 cycles after accept, result=13500, then in_ready=1 next cycle.
REQ-030 Defaults: number1=63, number2=511 -> result=32193 (max value, no overflow); number1=0, number2=511 -> result=0 after 3 cycles.
REQ-031 Backpressure: 12*25, out_ready=0 for 5 cycles in DONE -> out_valid and result=300 stable all 5 cycles, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-032 rst pulsed during RUN of 45*300 -> immediately out_valid=0, result=0, in_ready=1; subsequent 7*9 gives result=63 with no 13500 ever valid.
REQ-033 WA=6, WB=3, DIGIT=3: number1=63, number2=7 -> result=441 with out_valid 1 cycle after accept.
REQ-034 DONE with in_valid=1 and out_ready=1 same cycle -> operands not accepted that edge; accepted next edge in IDLE; random-operand stream vs. golden product, zero mismatches.

Source files
------------

// File: rtl/digit_serial_multiplier.sv
// Digit-serial unsigned multiplier: consumes DIGIT multiplier bits per cycle,
// LSB digit first, and holds the full-width product until the consumer takes it.
module digit_serial_multiplier #(
  parameter int WA    = 6,
  parameter int WB    = 9,
  parameter int DIGIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    number1,
  input  logic [WB-1:0]    number2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] result
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | one multiplier digit accumulated per cycle
  // DONE  | product held on result, out_valid high until out_ready

  localparam int ND = WB / DIGIT;
  localparam int WR = WA + WB;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [WA-1:0]   r_a;
  logic [WB-1:0]   r_b;
  logic [WR-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [WR-1:0]   r_result;

  logic [DIGIT-1:0] w_digit;
  logic [WR-1:0]    w_pp;
  logic [WR-1:0]    w_sum;
  logic             w_last;

  // r_b shifts right each step, so its low digit is always digit[k]
  assign w_digit = r_b[DIGIT-1:0];
  assign w_pp    = (WR'(r_a) * WR'(w_digit)) << (DIGIT * int'(r_cnt));
  assign w_sum   = r_acc + w_pp;
  assign w_last  = (r_cnt == CW'(ND - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= number1;
            r_b        <= number2;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_sum;
          r_b   <= r_b >> DIGIT;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result    <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // operands offered this edge are ignored; IDLE picks them up next edge
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Directed plus random-stream bench for digit_serial_multiplier with a
// scoreboard queue of golden products.
module tb_digit_serial_multiplier;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  number1;
  logic [8:0]  number2;
  logic [14:0] result;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [5:0]  number1_2;
  logic [2:0]  number2_2;
  logic [8:0]  result2;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [63:0] q[$];
  logic [63:0] last_exp;

  always #5 clk = ~clk;

  digit_serial_multiplier #(.WA(6), .WB(9), .DIGIT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .number1(number1), .number2(number2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result));

  digit_serial_multiplier #(.WA(6), .WB(3), .DIGIT(3)) dut_nd1 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .number1(number1_2), .number2(number2_2), .out_valid(out_valid2),
    .out_ready(out_ready2), .result(result2));

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offers operands for one edge, then scrambles the inputs.
  task automatic start_op(input int a, input int b);
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    number1  = 6'(a);
    number2  = 9'(b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    q.push_back(64'(a * b));
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
    number1 = 6'($urandom_range(0, 63));
    number2 = 9'($urandom_range(0, 511));
  endtask

  task automatic wait_done(input string tag);
    int          lat;
    logic [63:0] exp;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(ND));
    if (q.size() > 0) exp = q.pop_front();
    else exp = '1;
    last_exp = exp;
    chk({tag, "_result"}, 64'(result), exp);
  endtask

  task automatic finish_op(input string tag);
    tick();
    chk({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_result_held"}, 64'(result), last_exp);
  endtask

  initial begin
    int lat;
    int last_acc;
    int a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; number1 = '0; number2 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; number1_2 = '0; number2_2 = '0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    tick(); tick();

    // acceptance on the very first edge after reset release
    rst = 1'b0;
    start_op(45, 300);
    wait_done("45x300");
    finish_op("45x300");

    start_op(63, 511);
    wait_done("63x511");
    finish_op("63x511");

    start_op(0, 511);
    wait_done("0x511");
    finish_op("0x511");

    // backpressure in DONE
    out_ready = 1'b0;
    start_op(12, 25);
    wait_done("12x25");
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(result), 64'd300);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    finish_op("bp");

    // reset in the middle of RUN aborts the operation
    start_op(45, 300);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("abort_no_late_valid", 64'(out_valid), 64'd0);
    start_op(7, 9);
    wait_done("7x9");
    finish_op("7x9");

    // in_valid and out_ready together in DONE: not accepted until IDLE
    out_ready = 1'b0;
    start_op(5, 6);
    wait_done("5x6");
    number1 = 6'd11; number2 = 9'd13; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("done_no_accept_in_ready", 64'(in_ready), 64'd1);
    chk("done_no_accept_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("idle_accept_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    q.push_back(64'(11 * 13));
    wait_done("11x13");
    finish_op("11x13");

    // WB == DIGIT instance: single-cycle RUN
    number1_2 = 6'd63; number2_2 = 3'd7; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    number1_2 = 6'd1; number2_2 = 3'd1;
    lat = 0;
    while (!out_valid2 && lat < 40) begin
      tick();
      lat++;
    end
    chk("nd1_latency", 64'(lat), 64'd1);
    chk("nd1_result", 64'(result2), 64'd441);
    tick();
    chk("nd1_idle_in_ready", 64'(in_ready2), 64'd1);

    // back-to-back random stream with in_valid held high
    a = $urandom_range(0, 63);
    b = $urandom_range(0, 511);
    number1 = 6'(a); number2 = 9'(b); in_valid = 1'b1;
    tick();
    q.push_back(64'(a * b));
    last_acc = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_done("stream");
      a = $urandom_range(0, 63);
      b = $urandom_range(0, 511);
      number1 = 6'(a); number2 = 9'(b);
      tick();
      chk("stream_idle_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_accept_in_ready", 64'(in_ready), 64'd0);
      chk("stream_period", 64'(cyc - last_acc), 64'(ND + 2));
      last_acc = cyc;
      q.push_back(64'(a * b));
    end
    in_valid = 1'b0;
    wait_done("stream_last");
    finish_op("stream_last");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
